// File: rtl/core_op_sequencer.sv
// Host front-end for the image-processing core: issues ops, streams LOAD pixels, buffers results.
// Optional cycle-count reporting per op is enabled by defining SEQ_PERF_CNT_EN.
module core_op_sequencer #(
  parameter int INST_BW    = 4,
  parameter int INPUT_BW   = 8,
  parameter int IMG_SIZE   = 2048,
  parameter int OUTPUT_BW  = 14,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  input  logic [INST_BW-1:0]   i_cmd_mode,
  output logic                 o_cmd_ready,
  input  logic                 i_pix_valid,
  input  logic [INPUT_BW-1:0]  i_pix_data,
  output logic                 o_pix_ready,
  output logic                 o_op_valid,
  output logic [INST_BW-1:0]   o_op_mode,
  input  logic                 i_op_ready,
  output logic                 o_in_valid,
  output logic [INPUT_BW-1:0]  o_in_data,
  input  logic                 i_in_ready,
  input  logic                 i_out_valid,
  input  logic [OUTPUT_BW-1:0] i_out_data,
  output logic                 o_res_valid,
  output logic [OUTPUT_BW-1:0] o_res_data,
  output logic                 o_res_last,
  input  logic                 i_res_ready,
  output logic [5:0]           o_depth,
  output logic                 o_err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic                 o_perf_valid,
  output logic [19:0]          o_perf_cycles
`endif
);

  // state   | meaning
  // IDLE    | waiting for core ready and an admissible command
  // ISSUE   | o_op_valid high for one cycle, depth updated
  // LOAD    | streaming IMG_SIZE pixels into the core
  // COLLECT | pushing the op's expected results into the FIFO
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOAD, S_COLLECT} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LC_W  = $clog2(IMG_SIZE);

  localparam logic [INST_BW-1:0] OP_LOAD = 4'd0;
  localparam logic [INST_BW-1:0] OP_SCAD = 4'd5;
  localparam logic [INST_BW-1:0] OP_SCAU = 4'd6;
  localparam logic [INST_BW-1:0] OP_DISP = 4'd7;
  localparam logic [INST_BW-1:0] OP_CONV = 4'd8;
  localparam logic [INST_BW-1:0] OP_MEDF = 4'd9;
  localparam logic [INST_BW-1:0] OP_GRAD = 4'd10;

  state_t             state;
  logic               rdy_flag;
  logic [INST_BW-1:0] cur_op;
  logic [CNT_W-1:0]   n_req, n_exp;
  logic [LC_W-1:0]    cnt;

  logic [OUTPUT_BW:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;

  logic cmd_bad, issue, xfer, last_xfer, push, last_push, pop;

  always_comb begin
    n_req = '0;
    case (i_cmd_mode)
      OP_CONV:          n_req = CNT_W'(4);
      OP_DISP:          n_req = CNT_W'({o_depth, 2'b00});
      OP_MEDF, OP_GRAD: n_req = CNT_W'(16);
      default:          n_req = '0;
    endcase
  end

  assign cmd_bad   = i_cmd_mode > OP_GRAD;
  assign issue     = (state == S_IDLE) && rdy_flag && i_cmd_valid && !cmd_bad &&
                     ((CNT_W'(FIFO_DEPTH) - fifo_cnt) >= n_req);
  assign o_cmd_ready = issue || ((state == S_IDLE) && i_cmd_valid && cmd_bad);

  assign xfer      = (state == S_LOAD) && i_pix_valid && i_in_ready;
  assign last_xfer = xfer && (cnt == LC_W'(IMG_SIZE - 1));
  assign push      = (state == S_COLLECT) && i_out_valid;
  assign last_push = push && (cnt == LC_W'(n_exp) - LC_W'(1));
  assign pop       = o_res_valid && i_res_ready;

  assign o_in_valid  = (state == S_LOAD) && i_pix_valid;
  assign o_in_data   = (state == S_LOAD) ? i_pix_data : '0;
  assign o_pix_ready = (state == S_LOAD) && i_in_ready;

  assign o_res_valid = fifo_cnt != '0;
  assign {o_res_last, o_res_data} = o_res_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {last_push, i_out_data};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      rdy_flag   <= 1'b0;
      cur_op     <= '0;
      n_exp      <= '0;
      cnt        <= '0;
      o_op_valid <= 1'b0;
      o_op_mode  <= '0;
      o_depth    <= 6'd32;
      o_err      <= 1'b0;
    end else begin
      o_op_valid <= 1'b0;
      o_op_mode  <= '0;
      // Clear-on-issue wins so a held ready only re-arms after the op completes.
      if (issue)           rdy_flag <= 1'b0;
      else if (i_op_ready) rdy_flag <= 1'b1;

      if ((i_out_valid && state != S_COLLECT) ||
          (i_op_ready && (state == S_ISSUE || state == S_LOAD)) ||
          (i_op_ready && state == S_COLLECT && !last_push) ||
          ((state == S_IDLE) && i_cmd_valid && cmd_bad))
        o_err <= 1'b1;

      case (state)
        S_IDLE: if (issue) begin
          o_op_valid <= 1'b1;
          o_op_mode  <= i_cmd_mode;
          cur_op     <= i_cmd_mode;
          n_exp      <= n_req;
          cnt        <= '0;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (cur_op == OP_SCAD)      o_depth <= (o_depth == 6'd32) ? 6'd16 : 6'd8;
          else if (cur_op == OP_SCAU) o_depth <= (o_depth == 6'd8) ? 6'd16 : 6'd32;
          else if (cur_op == OP_LOAD) o_depth <= 6'd32;
          if (cur_op == OP_LOAD)    state <= S_LOAD;
          else if (n_exp != '0)     state <= S_COLLECT;
          else                      state <= S_IDLE;
        end
        S_LOAD: if (xfer) begin
          cnt <= cnt + LC_W'(1);
          if (last_xfer) state <= S_IDLE;
        end
        S_COLLECT: if (push) begin
          cnt <= cnt + LC_W'(1);
          if (last_push) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [19:0] perf_cnt, perf_next;
  assign perf_next = (perf_cnt == 20'hFFFFF) ? perf_cnt : perf_cnt + 20'd1;

  // The ISSUE cycle counts as cycle 1; the completing transfer/output is included.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      perf_cnt      <= '0;
      o_perf_valid  <= 1'b0;
      o_perf_cycles <= '0;
    end else begin
      o_perf_valid <= 1'b0;
      if (state == S_ISSUE) begin
        perf_cnt <= 20'd1;
        if (cur_op != OP_LOAD && n_exp == '0) begin
          o_perf_valid  <= 1'b1;
          o_perf_cycles <= 20'd1;
        end
      end else if (state == S_LOAD || state == S_COLLECT) begin
        perf_cnt <= perf_next;
        if (last_xfer || last_push) begin
          o_perf_valid  <= 1'b1;
          o_perf_cycles <= perf_next;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_op_sequencer.sv
// Directed bench for core_op_sequencer: LOAD streaming, depth scaling, FIFO admission/order, errors, reset abort.
module tb_core_op_sequencer;
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_cmd_valid, o_cmd_ready, i_pix_valid, o_pix_ready;
  logic [3:0]  i_cmd_mode, o_op_mode;
  logic [7:0]  i_pix_data, o_in_data;
  logic        o_op_valid, i_op_ready, o_in_valid, i_in_ready, i_out_valid;
  logic [13:0] i_out_data, o_res_data;
  logic        o_res_valid, o_res_last, i_res_ready, o_err;
  logic [5:0]  o_depth;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  core_op_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .i_cmd_mode(i_cmd_mode), .o_cmd_ready(o_cmd_ready),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
    .o_op_valid(o_op_valid), .o_op_mode(o_op_mode), .i_op_ready(i_op_ready),
    .o_in_valid(o_in_valid), .o_in_data(o_in_data), .i_in_ready(i_in_ready),
    .i_out_valid(i_out_valid), .i_out_data(i_out_data),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_last(o_res_last),
    .i_res_ready(i_res_ready), .o_depth(o_depth), .o_err(o_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic pulse_ready();
    i_op_ready = 1'b1;
    tick();
    i_op_ready = 1'b0;
  endtask

  // Ends in the slot after ISSUE, where the new depth is visible.
  task automatic issue(input logic [3:0] op, input string tag);
    i_cmd_valid = 1'b1;
    i_cmd_mode  = op;
    #1 check({tag, "_cmd_ready"}, o_cmd_ready, 1);
    tick();
    i_cmd_valid = 1'b0;
    #1 check({tag, "_op_valid"}, o_op_valid, 1);
    check({tag, "_op_mode"}, o_op_mode, op);
    tick();
  endtask

  task automatic do_load(input string tag);
    int xfers = 0;
    int bad = 0;
    i_pix_valid = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      i_in_ready = (c % 2 == 0);
      i_pix_data = 8'(xfers);
      #1;
      if (!o_in_valid) break;
      if (o_pix_ready !== i_in_ready || o_in_data !== i_pix_data) bad++;
      if (i_in_ready) xfers++;
      tick();
    end
    check({tag, "_xfers"}, xfers, 2048);
    check({tag, "_mirror"}, bad, 0);
    i_in_ready = 1'b1;
    #1 check({tag, "_pix_ready_idle"}, o_pix_ready, 0);
    i_pix_valid = 1'b0;
    i_in_ready  = 1'b0;
    tick();
  endtask

  task automatic collect(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      i_out_valid = 1'b1;
      i_out_data  = 14'(base + k);
      tick();
    end
    i_out_valid = 1'b0;
  endtask

  task automatic pop_check(input int n, input int base, input int last_at, input string tag);
    int bad = 0;
    i_res_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      if (!o_res_valid || o_res_data != 14'(base + k) || o_res_last != (k == last_at)) bad++;
      tick();
    end
    i_res_ready = 1'b0;
    check(tag, bad, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int lasts;
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_mode = '0; i_pix_valid = 1'b0; i_pix_data = '0;
    i_op_ready = 1'b0; i_in_ready = 1'b0; i_out_valid = 1'b0; i_out_data = '0; i_res_ready = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    #1 check("reset_depth", o_depth, 32);
    check("reset_res_valid", o_res_valid, 0);
    check("reset_err", o_err, 0);
    check("reset_op_valid", o_op_valid, 0);
    i_cmd_valid = 1'b1;
    #1 check("no_rdy_flag_hold", o_cmd_ready, 0);
    i_cmd_valid = 1'b0;
    tick();

    // LOAD with toggling core readiness
    pulse_ready();
    issue(4'd0, "load1");
    do_load("load1");
    #1 check("load1_err", o_err, 0);

    // Scale down to 8 then DISP (32 results)
    pulse_ready(); issue(4'd5, "scad1"); #1 check("scad1_depth", o_depth, 16);
    pulse_ready(); issue(4'd5, "scad2"); #1 check("scad2_depth", o_depth, 8);
    pulse_ready(); issue(4'd5, "scad3"); #1 check("scad3_depth", o_depth, 8);
    pulse_ready(); issue(4'd7, "disp8");
    collect(32, 100);
    pop_check(32, 100, 31, "disp8_fifo");
    #1 check("disp8_empty", o_res_valid, 0);

    // Scale up to 32, fill FIFO, CONV held until 4 free entries
    pulse_ready(); issue(4'd6, "scau1"); #1 check("scau1_depth", o_depth, 16);
    pulse_ready(); issue(4'd6, "scau2"); #1 check("scau2_depth", o_depth, 32);
    pulse_ready(); issue(4'd7, "disp32");
    collect(128, 1000);
    #1 check("disp32_full_valid", o_res_valid, 1);
    pulse_ready();
    i_cmd_valid = 1'b1;
    i_cmd_mode  = 4'd8;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      #1 check("conv_held", o_cmd_ready, 0);
      if (o_res_data != 14'(1000 + k) || o_res_last) bad++;
      i_res_ready = 1'b1;
      tick();
      i_res_ready = 1'b0;
    end
    check("disp32_head", bad, 0);
    #1 check("conv_admit", o_cmd_ready, 1);
    tick();
    i_cmd_valid = 1'b0;
    #1 check("conv_op_valid", o_op_valid, 1);
    check("conv_op_mode", o_op_mode, 8);
    tick();
    collect(4, 3000);
    pop_check(124, 1004, 123, "disp32_rest");
    pop_check(4, 3000, 3, "conv_fifo");

    // MEDF with simultaneous push and pop
    pulse_ready(); issue(4'd9, "medf");
    bad = 0; lasts = 0;
    i_res_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      i_out_valid = (k < 16);
      i_out_data  = 14'(5000 + k);
      #1;
      if (k >= 1 && k <= 16) begin
        if (!o_res_valid || o_res_data != 14'(5000 + k - 1) || o_res_last != (k == 16)) bad++;
      end else if (o_res_valid) bad++;
      if (o_res_valid && o_res_last) lasts++;
      tick();
    end
    i_out_valid = 1'b0;
    i_res_ready = 1'b0;
    check("medf_stream", bad, 0);
    check("medf_last_count", lasts, 1);
    #1 check("err_clean", o_err, 0);

    // Illegal opcode, stray output, sticky error
    pulse_ready();
    i_cmd_valid = 1'b1;
    i_cmd_mode  = 4'hF;
    #1 check("bad_op_consumed", o_cmd_ready, 1);
    tick();
    i_cmd_valid = 1'b0;
    #1 check("bad_op_not_issued", o_op_valid, 0);
    check("bad_op_err", o_err, 1);
    i_out_valid = 1'b1;
    i_out_data  = 14'd77;
    tick();
    i_out_valid = 1'b0;
    #1 check("stray_discard", o_res_valid, 0);
    issue(4'd1, "shfr_rdy_kept");
    tick(); tick();
    #1 check("err_sticky", o_err, 1);

    // Reset mid-LOAD after 700 pixels
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    #1 check("err_reset", o_err, 0);
    pulse_ready(); issue(4'd0, "load_abort");
    i_pix_valid = 1'b1;
    i_in_ready  = 1'b1;
    for (int c = 0; c < 700; c++) tick();
    i_rst_n = 1'b0;
    tick();
    #1 check("abort_in_valid", o_in_valid, 0);
    check("abort_depth", o_depth, 32);
    check("abort_res_valid", o_res_valid, 0);
    i_rst_n = 1'b1;
    i_pix_valid = 1'b0;
    i_in_ready  = 1'b0;
    tick();
    pulse_ready();
    issue(4'd0, "load2");
    do_load("load2");
    #1 check("load2_err", o_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/core_op_sequencer.md
Name: core_op_sequencer

Overview:
- Hardware host front-end that sits directly upstream of the image-processing core.
- Accepts a command stream (opcodes) and a pixel stream, and issues single-cycle ops to the core.
- Streams the 8x8x32 load image into the core.
- Tracks the current channel depth, counts the outputs expected from each op, and buffers core results into a FIFO with downstream backpressure.

Parameters:
- INST_BW, 4, opcode width
- INPUT_BW, 8, pixel width
- IMG_SIZE, 2048, pixels per LOAD (8*8*32)
- OUTPUT_BW, 14, core result width
- FIFO_DEPTH, 128, result FIFO entries (max outputs per op = 4*32)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_cmd_valid  in  1  command present
- i_cmd_mode  in  4  opcode
- o_cmd_ready  out  1  command accepted this cycle
- i_pix_valid  in  1  load pixel present
- i_pix_data  in  8  load pixel
- o_pix_ready  out  1  pixel consumed this cycle
- o_op_valid  out  1  to core i_op_valid
- o_op_mode  out  4  to core i_op_mode
- i_op_ready  in  1  from core o_op_ready
- o_in_valid  out  1  to core i_in_valid
- o_in_data  out  8  to core i_in_data
- i_in_ready  in  1  from core o_in_ready
- i_out_valid  in  1  from core o_out_valid
- i_out_data  in  14  from core o_out_data
- o_res_valid  out  1  FIFO not empty
- o_res_data  out  14  FIFO head
- o_res_last  out  1  head is final result of its op
- i_res_ready  in  1  downstream pop
- o_depth  out  6  current channel depth (8/16/32)
- o_err  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is synchronous, active-low.
- Reset values: all outputs 0 except o_depth=32. FIFO empty, state IDLE, rdy_flag=0.
- Reset mid-operation aborts any LOAD/COLLECT with no partial flush.
- rdy_flag: set on any cycle with i_op_ready=1; cleared on issue. Works whether the core pulses or holds o_op_ready.
- Opcode numbering (LOAD..GRAD): 0000 LOAD, 0001 SHFR, 0010 SHFL, 0011 SHFU, 0100 SHFD, 0101 SCAD, 0110 SCAU, 0111 DISP, 1000 CONV, 1001 MEDF, 1010 GRAD.
- Expected outputs n: CONV 4; DISP 4*depth; MEDF 16; GRAD 16; all others 0.
- States:
  - IDLE:
    - Issue condition: rdy_flag && i_cmd_valid && opcode<=1010 && FIFO free entries >= n.
    - On issue: o_cmd_ready=1 (combinational), and o_op_valid=1 with o_op_mode=opcode registered for exactly the next cycle. Go to ISSUE.
    - Opcode >1010: consumed (o_cmd_ready=1), never forwarded, o_err set. Stays in IDLE, rdy_flag kept.
  - ISSUE (1 cycle, o_op_valid high):
    - Depth update: SCAD 32->16, 16->8, 8 stays 8. SCAU 8->16, 16->32, 32 stays 32. LOAD sets 32.
    - Next state: LOAD -> LOAD; n>0 -> COLLECT; else -> IDLE.
  - LOAD:
    - o_in_valid=i_pix_valid, o_in_data=i_pix_data, o_pix_ready=i_in_ready.
    - Transfer = i_pix_valid && i_in_ready. 11-bit counter increments per transfer.
    - After transfer 2048 -> IDLE; o_in_valid=0 from the next cycle.
  - COLLECT:
    - Each i_out_valid pushes i_out_data; counter increments.
    - Push number n is tagged last=1 -> IDLE.
- i_out_valid outside COLLECT: data discarded, o_err set.
- i_op_ready=1 in COLLECT before count reaches n: o_err set.
- i_op_ready=1 in ISSUE or LOAD: o_err set.
- FIFO:
  - o_res_valid = !empty. Pop when o_res_valid && i_res_ready.
  - Simultaneous push and pop allowed, occupancy unchanged.
  - Full cannot be reached with a pending push, because of the free>=n admission check.
  - Pointers wrap modulo FIFO_DEPTH.
- o_pix_ready=0 and o_in_valid=0 outside LOAD.
- o_cmd_ready=0 outside IDLE.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - Adds o_perf_valid (1) and o_perf_cycles (20).
  - Counter clears on the cycle o_op_valid asserts and counts every cycle up to and including the last transfer/output of the op.
  - o_perf_valid pulses 1 cycle with the final count. Saturates at 2^20-1.
  - Ops with n=0 (non-LOAD) report 1.
- Undefined: ports and logic absent, all other behaviour identical.

Test Plan:
- Reset then LOAD with core i_in_ready toggling 1/0 -> exactly 2048 transfers; o_pix_ready mirrors i_in_ready; o_in_valid=0 the cycle after transfer 2048; o_err=0.
- SCAD, SCAD, SCAD, DISP -> o_depth 16, 8, 8; DISP collects 32 results; o_res_last only on the 32nd.
- SCAU from depth 8 twice then DISP -> depth 32; 128 results buffered with i_res_ready=0; next CONV is held (o_cmd_ready=0) until at least 4 entries are popped.
- MEDF with core emitting 16 outputs while i_res_ready=1 every cycle -> simultaneous push/pop, FIFO data order preserved, last tag on the 16th.
- Opcode 1111 then stray i_out_valid in IDLE -> o_op_valid never asserts for 1111; o_err=1 and remains until reset.
- Reset asserted mid-LOAD after 700 pixels -> next cycle o_in_valid=0, o_depth=32, FIFO empty; a fresh LOAD requires all 2048 pixels again.
